// File: rtl/fft_bfly_sequencer.sv
// fft_bfly_sequencer: radix-2 DIT FFT butterfly address/twiddle sequencer; `define FFT_HOLD_EN adds a hold input
module fft_bfly_sequencer #(
    parameter int LOG2N    = 3,
    parameter int BFLY_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FFT_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_even,
    output logic [LOG2N-1:0] rd_addr_odd,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_even,
    output logic [LOG2N-1:0] wr_addr_odd
);
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0] KMAX = '1;
    localparam logic [3:0] SMAX = 4'(LOG2N - 1);
    localparam logic [3:0] DMAX = 4'(BFLY_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t           r_state, w_next;
    logic [KW-1:0]    r_k;
    logic [3:0]       r_s, r_d;
    logic             w_run, w_issue, w_rd_en;
    logic [LOG2N-1:0] w_kx, w_mask, w_pos, w_even, w_odd;
    logic [KW-1:0]    w_tw;
    logic             r_we  [BFLY_LAT+1];
    logic [LOG2N-1:0] r_wae [BFLY_LAT+1];
    logic [LOG2N-1:0] r_wao [BFLY_LAT+1];

`ifdef FFT_HOLD_EN
    assign w_run = ~hold;
`else
    assign w_run = 1'b1;
`endif

    // butterfly k of stage s: insert a zero at bit s of k for the even operand
    assign w_issue = (r_state == ISSUE);
    assign w_rd_en = w_issue & w_run;
    assign w_kx    = {1'b0, r_k};
    assign w_mask  = (LOG2N'(1) << r_s) - LOG2N'(1);
    assign w_pos   = w_kx & w_mask;
    assign w_even  = ((w_kx & ~w_mask) << 1) | w_pos;
    assign w_odd   = w_even | (LOG2N'(1) << r_s);
    assign w_tw    = w_pos[KW-1:0] << (SMAX - r_s);

    assign busy         = (r_state == ISSUE) || (r_state == DRAIN);
    assign done         = (r_state == FIN) && w_run;
    assign stage        = busy ? r_s : 4'd0;
    assign rd_en        = w_rd_en;
    assign rd_addr_even = w_issue ? w_even : '0;
    assign rd_addr_odd  = w_issue ? w_odd : '0;
    assign tw_idx       = w_issue ? w_tw : '0;
    assign wr_en        = r_we[BFLY_LAT] & w_run;
    assign wr_addr_even = r_wae[BFLY_LAT];
    assign wr_addr_odd  = r_wao[BFLY_LAT];

    // next-state: one butterfly per ISSUE cycle, drain until the stage's last write lands
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  w_next = start ? ISSUE : IDLE;
            ISSUE: w_next = (r_k == KMAX) ? DRAIN : ISSUE;
            DRAIN: w_next = (r_d == DMAX) ? ((r_s == SMAX) ? FIN : ISSUE) : DRAIN;
            FIN:   w_next = IDLE;
        endcase
        if (!w_run) w_next = r_state;
    end

    // state register and butterfly/stage/drain counters, all frozen while held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_s     <= '0;
            r_d     <= '0;
        end else if (w_run) begin
            r_state <= w_next;
            r_k     <= w_issue ? r_k + 1'b1 : '0;
            r_d     <= (r_state == DRAIN) ? r_d + 4'd1 : 4'd0;
            r_s     <= (r_state == IDLE) ? 4'd0 :
                       (r_state == DRAIN && w_next == ISSUE) ? r_s + 4'd1 : r_s;
        end
    end

    // write-back delay line matching read latency plus butterfly pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= BFLY_LAT; i++) begin
                r_we[i]  <= 1'b0;
                r_wae[i] <= '0;
                r_wao[i] <= '0;
            end
        end else if (w_run) begin
            r_we[0]  <= w_rd_en;
            r_wae[0] <= rd_addr_even;
            r_wao[0] <= rd_addr_odd;
            for (int i = 1; i <= BFLY_LAT; i++) begin
                r_we[i]  <= r_we[i-1];
                r_wae[i] <= r_wae[i-1];
                r_wao[i] <= r_wao[i-1];
            end
        end
    end
endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// tb_fft_bfly_sequencer: scoreboard bench with a per-stage pair/twiddle model for fft_bfly_sequencer
module tb_fft_bfly_sequencer;
    localparam int LOG2N = 3;
    localparam int LAT   = 2;
    localparam int N     = 1 << LOG2N;
    localparam int N2    = N / 2;
    localparam int P     = N2 + LAT + 1;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
`ifdef FFT_HOLD_EN
    logic             hold = 1'b0;
`endif
    logic             busy, done, rd_en, wr_en;
    logic [3:0]       stage;
    logic [LOG2N-1:0] rd_addr_even, rd_addr_odd, wr_addr_even, wr_addr_odd;
    logic [LOG2N-2:0] tw_idx;

    fft_bfly_sequencer #(.LOG2N(LOG2N), .BFLY_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FFT_HOLD_EN
        .hold(hold),
`endif
        .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr_even(rd_addr_even), .rd_addr_odd(rd_addr_odd), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_even(wr_addr_even), .wr_addr_odd(wr_addr_odd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int s; int e; int o; int t;} ev_t;
    ev_t exp_rd[$], exp_wr[$];
    int  exp_done[$];
    int  bs = 0, be = 0;
    bit  mon_on = 1'b0;
    int  n_cmp = 0, n_bad = 0;
    ev_t m_e;

    task automatic chk(string nm, int act, int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
        end
    endtask

    function automatic int all_outs();
        return int'({busy, done, stage, rd_en, rd_addr_even, rd_addr_odd, tw_idx, wr_en, wr_addr_even, wr_addr_odd});
    endfunction

    // monitor: every strobe pops its expected event from the scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", int'(busy), int'(cyc >= bs && cyc < be));
            if (rd_en) begin
                if (exp_rd.size() == 0) chk("rd_en with empty queue", int'(rd_en), 0);
                else begin
                    m_e = exp_rd.pop_front();
                    chk("rd cycle", cyc, m_e.c);
                    chk("stage", int'(stage), m_e.s);
                    chk("rd_addr_even", int'(rd_addr_even), m_e.e);
                    chk("rd_addr_odd", int'(rd_addr_odd), m_e.o);
                    chk("tw_idx", int'(tw_idx), m_e.t);
                    if (exp_wr.size() > 0) chk("prior stage write outstanding", int'(exp_wr[0].s < m_e.s), 0);
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) chk("wr_en with empty queue", int'(wr_en), 0);
                else begin
                    m_e = exp_wr.pop_front();
                    chk("wr cycle", cyc, m_e.c);
                    chk("wr_addr_even", int'(wr_addr_even), m_e.e);
                    chk("wr_addr_odd", int'(wr_addr_odd), m_e.o);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done with empty queue", int'(done), 0);
                else begin
                    chk("done cycle", cyc, exp_done.pop_front());
                    chk("busy at done", int'(busy), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: stage s pairs every group of 2*span samples, twiddle step N/(2*span)
    task automatic push_model(int b);
        for (int s = 0; s < LOG2N; s++) begin
            int span = 1 << s;
            int k = 0;
            for (int g = 0; g < N / (2 * span); g++)
                for (int p = 0; p < span; p++) begin
                    ev_t e;
                    e.c = b + s * P + k;
                    e.s = s;
                    e.e = g * 2 * span + p;
                    e.o = e.e + span;
                    e.t = p * (N / (2 * span));
                    exp_rd.push_back(e);
                    e.c = e.c + LAT + 1;
                    exp_wr.push_back(e);
                    k++;
                end
        end
        exp_done.push_back(b + LOG2N * P);
    endtask

    task automatic run(int idle, bit repulse, bit abort);
        int b;
        repeat (idle) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        b = cyc;
        push_model(b);
        bs = b;
        be = b + LOG2N * P;
        if (abort) begin
            while (cyc < b + P + N2 + 1) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_rd.delete();
            exp_wr.delete();
            exp_done.delete();
            bs = 0;
            be = 0;
            @(negedge clk);
            chk("outputs after abort", all_outs(), 0);
            repeat (LAT + 4) tick();
            return;
        end
        while (cyc <= be) begin
            start = 1'b0;
            if (repulse && cyc >= b + P && cyc < b + P + N2)
                start = (cyc == b + P + 1) ? 1'b1 : 1'($urandom % 2);
            else if (repulse)
                start = 1'($urandom % 2);
            tick();
        end
        start = 1'b0;
        repeat (LAT + 2) tick();
        chk("reads left over", exp_rd.size(), 0);
        chk("writes left over", exp_wr.size(), 0);
        chk("done left over", exp_done.size(), 0);
    endtask

    initial begin
        repeat (2) tick();
        @(negedge clk);
        chk("reset outputs", all_outs(), 0);
        tick();
        rst = 1'b0;
        mon_on = 1'b1;
        run(2, 1'b0, 1'b0);
        run(int'($urandom % 5), 1'b1, 1'b0);
        run(0, 1'b0, 1'b1);
        run(1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run(int'($urandom % 4), 1'($urandom % 2), 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
